// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Four-requester round-robin arbiter. One requester owns the shared resource
// at a time. The grant is held until the owner asserts done, drops its
// request, or has held the grant for MAX_HOLD cycles. After every release
// there is at least one cycle with no grant before the next arbitration.
//
// Ports
//   clk        system clock, rising edge active
//   rst        asynchronous, active-high reset
//   req        request vector, req[i]=1 means requester i wants the resource
//   done       owner releases the resource (ignored while no grant is active)
//   gnt        registered one-hot grant, 0 when idle
//   gnt_id     registered binary index of the owner, 0 when idle
//   gnt_valid  registered, equals |gnt
//   timeout    one-cycle pulse after a grant is forcibly released by MAX_HOLD
//
// FSM states
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no grant; arbitrate among req starting at ptr
//   BUSY  | grant held by gnt_id; watch for done, owner drop or hold limit
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // hold_cnt counts completed hold cycles; the grant is released on the edge
  // where it reaches MAX_HOLD-1, giving exactly MAX_HOLD visible cycles.
  localparam bit             LIMIT_EN    = (MAX_HOLD != 0);
  localparam int             HOLD_LAST_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
  localparam logic [7:0]     HOLD_LAST   = 8'(HOLD_LAST_I);
  localparam logic [N_REQ-1:0] ONE       = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;

  // Rotating priority search: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  logic       win_any;
  logic [1:0] win_id;
  logic [1:0] cand;

  always_comb begin
    win_any = 1'b0;
    win_id  = ptr;
    cand    = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!win_any && req[cand]) begin
        win_any = 1'b1;
        win_id  = cand;
      end
    end
  end

  logic rel_done;
  logic rel_drop;
  logic rel_limit;
  logic release_now;

  always_comb begin
    rel_done    = done;
    rel_drop    = !req[gnt_id];
    rel_limit   = LIMIT_EN && (hold_cnt == HOLD_LAST);
    release_now = rel_done || rel_drop || rel_limit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= 8'd0;
      gnt       <= '0;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      // timeout is a single-cycle pulse unless re-armed below
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            gnt       <= ONE << win_id;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            hold_cnt  <= 8'd0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            gnt       <= '0;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_id + 2'd1;
            state     <= IDLE;
            // A voluntary release in the same cycle as the limit wins.
            timeout   <= rel_limit && !rel_done && !rel_drop;
          end else begin
            hold_cnt  <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
Four-requester round-robin arbiter that shares one downstream resource, such as a priority_enc-driven datapath, between independent clients. It grants exactly one requester at a time, holds the grant until the owner signals done or drops its request, and enforces a programmable hold limit so no requester can starve the others. Grant outputs are registered, one-hot, and accompanied by an encoded index and a valid flag.

Parameters:
N_REQ, 4, number of requesters; fixed at 4, which sets gnt_id to 2 bits.
MAX_HOLD, 8, maximum consecutive cycles one grant may be held; 0 disables the limit; legal range 0..255.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
req  input  4  request vector; req[i]=1 means requester i wants the resource
done  input  1  current owner releases the resource; ignored while gnt_valid=0
gnt  output  4  one-hot grant, registered; 0000 when no grant
gnt_id  output  2  binary index of the granted requester; 00 when no grant
gnt_valid  output  1  1 while any grant is active (equals |gnt)
timeout  output  1  one-cycle pulse when a grant is forcibly released by the MAX_HOLD limit

Behaviour:
- Reset is asynchronous: rst=1 clears outputs immediately, without waiting for a clk edge: gnt=0000, gnt_id=00, gnt_valid=0, timeout=0.
- Reset also clears internal state: ptr=0, hold_cnt=0, state=IDLE.
- Reset mid-grant aborts the grant with no timeout pulse.
- ptr[1:0] is the highest-priority index for the next arbitration.
- Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- State IDLE:
  - On a clk edge with any req bit set, the first set bit in search order wins.
  - gnt, gnt_id and gnt_valid update at that edge, so grant latency is 1 cycle from the sampled request.
  - hold_cnt is set to 0 and the state moves to BUSY.
  - With req=0000, the block stays in IDLE.
- State BUSY:
  - gnt is held stable.
  - hold_cnt increments on each edge that does not release the grant.
  - Release conditions, sampled at a clk edge:
    - (a) done=1;
    - (b) req[owner]=0;
    - (c) MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and neither (a) nor (b) holds.
  - On release: gnt, gnt_id and gnt_valid clear at that edge; ptr becomes owner+1 mod 4; the state moves to IDLE.
  - timeout=1 in the following cycle only for case (c), and deasserts at the next edge.
  - Net effect: the grant is visible for exactly MAX_HOLD cycles on timeout.
  - There is always at least one idle cycle (gnt=0000) between consecutive grants.
  - A new grant appears at the edge after release at the earliest.
- Simultaneous events:
  - done and the hold limit in the same cycle count as a normal release (timeout stays 0).
  - done and req[owner]=0 together count as a single release.
  - req changes of non-owners during BUSY are ignored until the next IDLE arbitration.
- A lone requester that keeps req high after a timeout is re-granted after the one idle cycle, because the search wraps around to it.
- Fairness: a requester holding req high is granted within 3*(MAX_HOLD+1)+4 cycles when MAX_HOLD!=0.
- Invariants:
  - gnt is zero or one-hot.
  - gnt_id == index of gnt whenever gnt_valid=1.
  - gnt_valid == |gnt.
  - timeout=1 implies gnt_valid=0.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with req=1111 -> gnt=0000, gnt_id=00, gnt_valid=0, timeout=0 throughout; rst deasserted at a negedge -> first grant gnt=0001 one edge later.
2. Single requester: from IDLE with ptr=0, req=0100 -> next edge gnt=0100, gnt_id=10, gnt_valid=1; pulse done for 1 cycle -> gnt=0000 after that edge; ptr=3, checked by then asserting req=1001 -> gnt=1000, gnt_id=11.
3. Round-robin: req=1111 held, done pulsed in the 2nd cycle of each grant -> grant sequence gnt_id 0,1,2,3,0, each separated by exactly one gnt=0000 cycle.
4. Timeout: MAX_HOLD=8, req=0001 held, done=0 -> gnt=0001 for exactly 8 cycles, then gnt=0000 with timeout=1 for 1 cycle, then gnt=0001 again.
5. Coincident done at the limit: MAX_HOLD=8, done=1 in the 8th grant cycle -> gnt drops and timeout stays 0. Owner-drop variant: req 0010->0000 mid-grant -> release next edge, no timeout.
6. Async reset mid-grant: gnt=0010 active, rst pulsed between clock edges -> all outputs 0 before the next posedge; after rst=0 with req=1111 -> gnt=0001 (ptr reset to 0).
